// File: rtl/text_pkg.sv
// rtl/text_pkg.sv - shared constants, types and helpers for the text renderer
// Purpose: character-buffer geometry, write-FSM state type, cell address
//          arithmetic and RGB332 unpacking helpers.
// Ports:   none (package).
package text_pkg;

  localparam int COLS      = 80;
  localparam int ROWS      = 30;
  localparam int BUF_DEPTH = COLS * ROWS;
  localparam int CHAR_W    = 8;
  localparam int CHAR_H    = 16;
  localparam logic [6:0] SPACE = 7'h20;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } wr_state_t;

  // row*80 + col as (row<<6)+(row<<4)+col; worst case 31*80+127 still fits 12 bits.
  function automatic logic [11:0] cell_addr(input logic [4:0] row, input logic [6:0] col);
    logic [11:0] r;
    r = {7'd0, row};
    return (r << 6) + (r << 4) + {5'd0, col};
  endfunction

  function automatic logic [2:0] rgb_red(input logic [7:0] c);
    return c[7:5];
  endfunction

  function automatic logic [2:0] rgb_green(input logic [7:0] c);
    return c[4:2];
  endfunction

  function automatic logic [1:0] rgb_blue(input logic [7:0] c);
    return c[1:0];
  endfunction

endpackage

// File: rtl/font_rom_8x16.sv
// rtl/font_rom_8x16.sv - synchronous 8x16 glyph ROM
// Purpose: returns one 8-pixel glyph line, MSB = leftmost pixel, one cycle
//          after the address is presented. Glyphs not listed are blank.
// Ports:   clk_50 - clock
//          addr   - {char[6:0], line[3:0]}
//          data_q - registered glyph line
module font_rom_8x16 (
  input  logic        clk_50,
  input  logic [10:0] addr,
  output logic [7:0]  data_q
);

  logic [7:0] data_d;

  always_comb begin
    data_d = 8'h00;
    case (addr)
      // 'A'
      11'h412:                                  data_d = 8'h10;
      11'h413:                                  data_d = 8'h38;
      11'h414:                                  data_d = 8'h6C;
      11'h415, 11'h416, 11'h418, 11'h419,
      11'h41A, 11'h41B:                         data_d = 8'hC6;
      11'h417:                                  data_d = 8'hFE;
      // 'B'
      11'h422, 11'h42B:                         data_d = 8'hFC;
      11'h423, 11'h424, 11'h425, 11'h427,
      11'h428, 11'h429, 11'h42A:                data_d = 8'h66;
      11'h426:                                  data_d = 8'h7C;
      default: begin
        // 0x7F is a solid block, handy as a full-cell test pattern.
        if (addr[10:4] == 7'h7F) data_d = 8'hFF;
      end
    endcase
  end

  always_ff @(posedge clk_50) begin
    data_q <= data_d;
  end

endmodule

// File: rtl/text_renderer.sv
// rtl/text_renderer.sv - 80x30 text-mode pixel colour stage for VGA
// Purpose: character buffer with valid/ready write port and clear sweep,
//          4-stage pixel pipeline (address, buffer read, font read, colour)
//          with blinking underline cursor and matching sync delay.
// Ports:   clk_50, rst (async, active-low)
//          pixel_column/pixel_row/video_on/hsync_in/vsync_in - timing input
//          wr_valid/wr_ready/wr_col/wr_row/wr_char - character write port
//          clr_req/clr_busy - buffer clear request and sweep status
//          cursor_en/cursor_col/cursor_row - cursor position
//          red_out/green_out/blue_out/hsync_out/vsync_out - to connector
module text_renderer #(
  parameter int         COLS         = 80,
  parameter int         ROWS         = 30,
  parameter logic [7:0] FG_COLOR     = 8'hFF,
  parameter logic [7:0] BG_COLOR     = 8'h00,
  parameter int         BLINK_FRAMES = 30
) (
  input  logic       clk_50,
  input  logic       rst,
  input  logic [9:0] pixel_column,
  input  logic [9:0] pixel_row,
  input  logic       video_on,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [6:0] wr_col,
  input  logic [4:0] wr_row,
  input  logic [6:0] wr_char,
  input  logic       clr_req,
  output logic       clr_busy,
  input  logic       cursor_en,
  input  logic [6:0] cursor_col,
  input  logic [4:0] cursor_row,
  output logic [2:0] red_out,
  output logic [2:0] green_out,
  output logic [1:0] blue_out,
  output logic       hsync_out,
  output logic       vsync_out
);

  import text_pkg::*;

  localparam logic [6:0]  COLS_L     = 7'(COLS);
  localparam logic [4:0]  ROWS_L     = 5'(ROWS);
  localparam logic [11:0] LAST_ADDR  = 12'(BUF_DEPTH - 1);
  localparam logic [7:0]  BLINK_LAST = 8'(BLINK_FRAMES - 1);
  localparam logic [9:0]  H_VIS      = 10'd640;
  localparam logic [9:0]  V_VIS      = 10'd480;

  // Write FSM and blink state
  wr_state_t   state_q, state_d;
  logic [11:0] clr_addr_q, clr_addr_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        blink_vis_q, blink_vis_d;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [6:0]  wr_data;

  // S0: registered timing inputs
  logic [9:0] col0_q, col0_d, row0_q, row0_d;
  logic       vid0_q, vid0_d, hs0_q, hs0_d, vs0_q, vs0_d;
  // S1: buffer read
  logic [6:0] rd_char_q;
  logic [3:0] gy1_q, gy1_d;
  logic [2:0] bx1_q, bx1_d;
  logic       vis1_q, vis1_d, cur1_q, cur1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  // S2: font read
  logic [7:0] line2_q;
  logic [2:0] bx2_q, bx2_d;
  logic       vis2_q, vis2_d, cur2_q, cur2_d, hs2_q, hs2_d, vs2_q, vs2_d;
  // S3: colour
  logic [7:0] rgb_q, rgb_d;
  logic       hs3_q, hs3_d, vs3_q, vs3_d;

  logic [6:0]  cell_col;
  logic [4:0]  cell_row;
  logic        in_area;
  logic [11:0] rd_addr;
  logic        cur_hit;
  logic        vs_fall;
  logic        pixel_on;

  logic [6:0] char_mem [0:BUF_DEPTH-1];

  // Write FSM. clr_req is only honoured in IDLE and wins over a write in the
  // same cycle, which is why wr_ready also depends on it.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    wr_en      = 1'b0;
    wr_addr    = clr_addr_q;
    wr_data    = SPACE;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d    = CLEAR;
          clr_addr_d = 12'd0;
        end else if (wr_valid && (wr_col < COLS_L) && (wr_row < ROWS_L)) begin
          wr_en   = 1'b1;
          wr_addr = cell_addr(wr_row, wr_col);
          wr_data = wr_char;
        end
      end
      CLEAR: begin
        wr_en = 1'b1;
        if (clr_addr_q == LAST_ADDR) begin
          state_d    = IDLE;
          clr_addr_d = 12'd0;
        end else begin
          clr_addr_d = clr_addr_q + 12'd1;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  assign wr_ready = (state_q == IDLE) && !clr_req;
  assign clr_busy = (state_q == CLEAR);

  // Display pipeline and blink counter
  always_comb begin
    col0_d = pixel_column;
    row0_d = pixel_row;
    vid0_d = video_on;
    hs0_d  = hsync_in;
    vs0_d  = vsync_in;

    cell_col = col0_q[9:3];
    cell_row = row0_q[8:4];
    in_area  = (col0_q < H_VIS) && (row0_q < V_VIS);
    // Off-screen coordinates can decode past the last cell; park the read
    // at cell 0 since the pixel is blanked anyway.
    rd_addr  = in_area ? cell_addr(cell_row, cell_col) : 12'd0;
    cur_hit  = cursor_en && (cell_col == cursor_col) && (cell_row == cursor_row)
               && (row0_q[3:1] == 3'b111);

    gy1_d  = row0_q[3:0];
    bx1_d  = col0_q[2:0];
    vis1_d = vid0_q && in_area;
    cur1_d = cur_hit;
    hs1_d  = hs0_q;
    vs1_d  = vs0_q;

    bx2_d  = bx1_q;
    vis2_d = vis1_q;
    cur2_d = cur1_q;
    hs2_d  = hs1_q;
    vs2_d  = vs1_q;

    // ~bx is 7-bx: pixel 0 is the glyph line MSB.
    pixel_on = line2_q[~bx2_q] | (cur2_q & blink_vis_q);
    rgb_d    = !vis2_q ? 8'h00 : (pixel_on ? FG_COLOR : BG_COLOR);
    hs3_d    = hs2_q;
    vs3_d    = vs2_q;

    vs_fall     = vs1_q & ~vs0_q;
    frame_cnt_d = frame_cnt_q;
    blink_vis_d = blink_vis_q;
    if (vs_fall) begin
      if (frame_cnt_q == BLINK_LAST) begin
        frame_cnt_d = 8'd0;
        blink_vis_d = ~blink_vis_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_50 or negedge rst) begin
    if (!rst) begin
      state_q     <= CLEAR;
      clr_addr_q  <= 12'd0;
      frame_cnt_q <= 8'd0;
      blink_vis_q <= 1'b1;
      col0_q <= 10'd0;  row0_q <= 10'd0;
      vid0_q <= 1'b0;   hs0_q  <= 1'b1;  vs0_q <= 1'b1;
      gy1_q  <= 4'd0;   bx1_q  <= 3'd0;
      vis1_q <= 1'b0;   cur1_q <= 1'b0;  hs1_q <= 1'b1;  vs1_q <= 1'b1;
      bx2_q  <= 3'd0;
      vis2_q <= 1'b0;   cur2_q <= 1'b0;  hs2_q <= 1'b1;  vs2_q <= 1'b1;
      rgb_q  <= 8'h00;  hs3_q  <= 1'b1;  vs3_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      frame_cnt_q <= frame_cnt_d;
      blink_vis_q <= blink_vis_d;
      col0_q <= col0_d;  row0_q <= row0_d;
      vid0_q <= vid0_d;  hs0_q  <= hs0_d;   vs0_q <= vs0_d;
      gy1_q  <= gy1_d;   bx1_q  <= bx1_d;
      vis1_q <= vis1_d;  cur1_q <= cur1_d;  hs1_q <= hs1_d;  vs1_q <= vs1_d;
      bx2_q  <= bx2_d;
      vis2_q <= vis2_d;  cur2_q <= cur2_d;  hs2_q <= hs2_d;  vs2_q <= vs2_d;
      rgb_q  <= rgb_d;   hs3_q  <= hs3_d;   vs3_q <= vs3_d;
    end
  end

  // Simple dual-port buffer: read-during-write to one cell returns old data.
  always_ff @(posedge clk_50) begin
    if (wr_en) char_mem[wr_addr] <= wr_data;
    rd_char_q <= char_mem[rd_addr];
  end

  font_rom_8x16 u_font (
    .clk_50 (clk_50),
    .addr   ({rd_char_q, gy1_q}),
    .data_q (line2_q)
  );

  assign red_out   = rgb_red(rgb_q);
  assign green_out = rgb_green(rgb_q);
  assign blue_out  = rgb_blue(rgb_q);
  assign hsync_out = hs3_q;
  assign vsync_out = vs3_q;

endmodule

// File: tb/tb_text_renderer.sv
// tb/tb_text_renderer.sv - directed self-checking bench for text_renderer
module tb_text_renderer;

  logic       clk_50 = 1'b0;
  logic       rst;
  logic [9:0] pixel_column, pixel_row;
  logic       video_on, hsync_in, vsync_in;
  logic       wr_valid, wr_ready;
  logic [6:0] wr_col, wr_char;
  logic [4:0] wr_row;
  logic       clr_req, clr_busy;
  logic       cursor_en;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;
  logic [2:0] red_out, green_out;
  logic [1:0] blue_out;
  logic       hsync_out, vsync_out;
  logic [7:0] rgb;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] font_a [0:16-1];

  always #10 clk_50 = ~clk_50;

  assign rgb = {red_out, green_out, blue_out};

  text_renderer dut (
    .clk_50(clk_50), .rst(rst),
    .pixel_column(pixel_column), .pixel_row(pixel_row), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_col(wr_col), .wr_row(wr_row),
    .wr_char(wr_char), .clr_req(clr_req), .clr_busy(clr_busy),
    .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  task automatic drive(input logic [9:0] c, input logic [9:0] r,
                       input logic v, input logic hs, input logic vs);
    pixel_column = c;
    pixel_row    = r;
    video_on     = v;
    hsync_in     = hs;
    vsync_in     = vs;
  endtask

  task automatic test_reset();
    int busy = 0;
    bit rdy_bad = 1'b0;
    rst = 1'b0;
    drive(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
    repeat (3) tick();
    n_checks++; if (rgb !== 8'h00) begin n_fail++; $display("FAIL reset_rgb got %h want 00", rgb); end
    n_checks++; if (hsync_out !== 1'b1) begin n_fail++; $display("FAIL reset_hsync got %b want 1", hsync_out); end
    n_checks++; if (vsync_out !== 1'b1) begin n_fail++; $display("FAIL reset_vsync got %b want 1", vsync_out); end
    n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ready got %b want 0", wr_ready); end
    n_checks++; if (clr_busy !== 1'b1) begin n_fail++; $display("FAIL reset_clr_busy got %b want 1", clr_busy); end
    rst = 1'b1;
    @(negedge clk_50);
    while (clr_busy === 1'b1 && busy < 5000) begin
      busy++;
      if (wr_ready !== 1'b0) rdy_bad = 1'b1;
      @(negedge clk_50);
    end
    n_checks++; if (busy != 2400) begin n_fail++; $display("FAIL reset_sweep_len got %0d want 2400", busy); end
    n_checks++; if (rdy_bad) begin n_fail++; $display("FAIL reset_ready_in_sweep got 1 want 0"); end
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after got %b want 1", wr_ready); end
    tick();
    // Sparse sample of the whole frame: all cells hold spaces.
    for (int i = 0; i < 204; i++) begin
      if (i >= 4) begin
        n_checks++;
        if (rgb !== 8'h00) begin n_fail++; $display("FAIL blank_frame[%0d] got %h want 00", i - 4, rgb); end
      end
      if (i < 200) drive(10'((i * 37) % 640), 10'((i * 53) % 480), 1'b1, 1'b1, 1'b1);
      else         drive(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
      tick();
    end
  endtask

  task automatic test_char_a();
    logic [7:0] expv [0:127];
    logic [7:0] ln;
    wr_valid = 1'b1; wr_col = 7'd0; wr_row = 5'd0; wr_char = 7'h41;
    #1;
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL a_wr_ready got %b want 1", wr_ready); end
    tick();
    wr_valid = 1'b0;
    for (int i = 0; i < 128; i++) begin
      ln = font_a[i / 8];
      expv[i] = ln[7 - (i % 8)] ? 8'hFF : 8'h00;
    end
    for (int i = 0; i < 132; i++) begin
      if (i >= 4) begin
        n_checks++;
        if (rgb !== expv[i - 4]) begin
          n_fail++; $display("FAIL glyph_a x=%0d y=%0d got %h want %h", (i - 4) % 8, (i - 4) / 8, rgb, expv[i - 4]);
        end
      end
      if (i < 128) drive(10'(i % 8), 10'(i / 8), 1'b1, 1'b1, 1'b1);
      else         drive(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
      tick();
    end
  endtask

  task automatic test_sync();
    logic lv, ev, obs;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 114; i++) begin
        if (i >= 4) begin
          ev  = !((i - 4) >= 5 && (i - 4) < 101);
          obs = (p == 0) ? hsync_out : vsync_out;
          n_checks++;
          if (obs !== ev) begin
            n_fail++; $display("FAIL %s_delay t=%0d got %b want %b", (p == 0) ? "hsync" : "vsync", i - 4, obs, ev);
          end
        end
        lv = (i < 110) ? !(i >= 5 && i < 101) : 1'b1;
        drive(10'd0, 10'd0, 1'b0, (p == 0) ? lv : 1'b1, (p == 1) ? lv : 1'b1);
        tick();
      end
    end
  endtask

  task automatic test_range();
    logic [9:0] cs [0:4];
    logic [9:0] rs [0:4];
    logic       vs [0:4];
    logic [7:0] es [0:4];
    // 'A' at (0,1); then an out-of-range write whose naive address aliases (0,1).
    wr_valid = 1'b1; wr_col = 7'd0; wr_row = 5'd1; wr_char = 7'h41;
    tick();
    wr_col = 7'd80; wr_row = 5'd0; wr_char = 7'h20;
    #1;
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL oor_handshake got %b want 1", wr_ready); end
    tick();
    wr_valid = 1'b0;
    cs = '{10'd0,  10'd640, 10'd0,   10'd0, 10'd0};
    rs = '{10'd23, 10'd7,   10'd487, 10'd7, 10'd7};
    vs = '{1'b1,   1'b1,    1'b1,    1'b0,  1'b1};
    es = '{8'hFF,  8'h00,   8'h00,   8'h00, 8'hFF};
    for (int i = 0; i < 9; i++) begin
      if (i >= 4) begin
        n_checks++;
        if (rgb !== es[i - 4]) begin
          n_fail++; $display("FAIL range_px[%0d] (%0d,%0d) got %h want %h", i - 4, cs[i - 4], rs[i - 4], rgb, es[i - 4]);
        end
      end
      if (i < 5) drive(cs[i], rs[i], vs[i], 1'b1, 1'b1);
      else       drive(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
      tick();
    end
  endtask

  task automatic test_clear_priority();
    int busy = 0;
    drive(10'd632, 10'd471, 1'b1, 1'b1, 1'b1);
    wr_valid = 1'b1; wr_col = 7'd79; wr_row = 5'd29; wr_char = 7'h41; clr_req = 1'b1;
    #1;
    n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL clr_prio_ready got %b want 0", wr_ready); end
    n_checks++; if (clr_busy !== 1'b0) begin n_fail++; $display("FAIL clr_prio_busy_pre got %b want 0", clr_busy); end
    tick();
    wr_valid = 1'b0; clr_req = 1'b0;
    @(negedge clk_50);
    while (clr_busy === 1'b1 && busy < 5000) begin
      busy++;
      clr_req = (busy == 100);
      if (busy == 30) begin
        n_checks++;
        if (rgb !== 8'h00) begin n_fail++; $display("FAIL clr_prio_no_write got %h want 00", rgb); end
      end
      @(negedge clk_50);
    end
    clr_req = 1'b0;
    n_checks++; if (busy != 2400) begin n_fail++; $display("FAIL clr_sweep_len got %0d want 2400", busy); end
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL clr_ready_after got %b want 1", wr_ready); end
    tick();
  endtask

  task automatic test_cursor_blink();
    logic [9:0] cs [0:3];
    logic [9:0] rs [0:3];
    logic [7:0] es [0:3];
    logic [7:0] cexp;
    rst = 1'b0;
    drive(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
    tick();
    rst = 1'b1;
    cursor_en = 1'b1; cursor_col = 7'd5; cursor_row = 5'd2;
    cs = '{10'd40, 10'd47, 10'd48, 10'd40};
    rs = '{10'd46, 10'd47, 10'd46, 10'd45};
    for (int k = 0; k <= 60; k++) begin
      if (k == 0 || k == 29 || k == 30 || k == 59 || k == 60) begin
        cexp = (k < 30 || k == 60) ? 8'hFF : 8'h00;
        es = '{cexp, cexp, 8'h00, 8'h00};
        for (int i = 0; i < 8; i++) begin
          if (i >= 4) begin
            n_checks++;
            if (rgb !== es[i - 4]) begin
              n_fail++; $display("FAIL cursor frame=%0d px=%0d got %h want %h", k, i - 4, rgb, es[i - 4]);
            end
          end
          if (i < 4) drive(cs[i], rs[i], 1'b1, 1'b1, 1'b1);
          else       drive(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
          tick();
        end
      end
      drive(10'd0, 10'd0, 1'b0, 1'b1, 1'b0);
      tick();
      drive(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
      repeat (2) tick();
    end
    cursor_en = 1'b0;
  endtask

  initial begin
    font_a = '{8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
               8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00};
    rst = 1'b0;
    drive(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
    wr_valid = 1'b0; wr_col = 7'd0; wr_row = 5'd0; wr_char = 7'd0;
    clr_req = 1'b0; cursor_en = 1'b0; cursor_col = 7'd0; cursor_row = 5'd0;
    test_reset();
    test_char_a();
    test_sync();
    test_range();
    test_clear_priority();
    test_cursor_blink();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/text_renderer.md
Name: text_renderer

Overview:
- Pixel-colour stage directly downstream of the VGA timing controller.
- Holds an 80x30 character buffer of 7-bit ASCII, written by the game logic through a valid/ready port.
- Converts each pixel coordinate into 3/3/2 RGB using an 8x16 font and draws a blinking underline cursor.
- Delays hsync/vsync to match its pixel pipeline, so everything it drives to the VGA connector stays aligned.

Parameters:
- COLS, 80: text columns (640/8).
- ROWS, 30: text rows (480/16).
- FG_COLOR, 8'hFF: foreground colour {r[2:0],g[2:0],b[1:0]}.
- BG_COLOR, 8'h00: background colour, same packing.
- BLINK_FRAMES, 30: frames per cursor blink half-period.

Ports:
- clk_50  in  1  50 MHz system clock.
- rst  in  1  asynchronous, active-low reset.
- pixel_column  in  10  current pixel x from timing controller.
- pixel_row  in  10  current pixel y from timing controller.
- video_on  in  1  high inside the visible area.
- hsync_in  in  1  horizontal sync, active low.
- vsync_in  in  1  vertical sync, active low.
- wr_valid  in  1  character write request.
- wr_ready  out  1  write accepted this cycle when high together with wr_valid.
- wr_col  in  7  target text column.
- wr_row  in  5  target text row.
- wr_char  in  7  ASCII code.
- clr_req  in  1  single-cycle pulse: fill buffer with 0x20.
- clr_busy  out  1  clear sweep in progress.
- cursor_en  in  1  cursor enable.
- cursor_col  in  7  cursor column.
- cursor_row  in  5  cursor row.
- red_out  out  3  red to connector.
- green_out  out  3  green to connector.
- blue_out  out  2  blue to connector.
- hsync_out  out  1  delayed hsync.
- vsync_out  out  1  delayed vsync.

Behaviour:
- Reset: rst is asynchronous, active-low; clock is clk_50.
- Reset output values: RGB = 0, hsync_out = 1, vsync_out = 1, wr_ready = 0, clr_busy = 1.
- Reset state: FSM = CLEAR with clear address 0, frame counter 0, blink phase visible.
- Write FSM, IDLE:
  - wr_ready = 1, clr_busy = 0.
  - wr_valid & in-range (col < COLS, row < ROWS): write buf[row*80+col] = wr_char on the same edge.
  - Out-of-range request: still handshaken, write dropped.
  - clr_req: go to CLEAR, address 0. clr_req has priority over a simultaneous wr_valid; that write is not accepted.
- Write FSM, CLEAR:
  - wr_ready = 0, clr_busy = 1.
  - Write 0x20 at the current address each clock, address increments.
  - After address COLS*ROWS-1 (2399), return to IDLE. The sweep is 2400 cycles.
  - clr_req during CLEAR is ignored.
  - Reset mid-sweep restarts the sweep at address 0.
- Address arithmetic: 12 bits, computed as (row<<6)+(row<<4)+col. No multiplier.
- Buffer: 2400x7 simple dual-port RAM with one write port and one synchronous display read port. Display reads never stall writes.
- Display pipeline runs every clk_50 cycle. Total latency is 4 cycles, identical for RGB, hsync_out and vsync_out.
  - S0: register inputs; compute cell address from column[9:3] and row[8:4].
  - S1: buffer read → char; carry glyph_y = row[3:0] and bit_x = column[2:0].
  - S2: font ROM read with {char, glyph_y} → 8-bit glyph line.
  - S3: pixel = line[7 - bit_x], OR cursor term. Register RGB = pixel ? FG_COLOR : BG_COLOR.
- Blanking: RGB is forced to 0 when the delayed video_on = 0, or when column ≥ 640, or when row ≥ 480. Column 640 can arrive with video_on high; it must still be black.
- Cursor term: cursor_en & cell == (cursor_col, cursor_row) & glyph_y ∈ {14, 15} & blink phase visible.
- Blink: a vsync_in falling edge, detected at S0, increments the frame counter. At BLINK_FRAMES-1 the counter wraps to 0 and the blink phase toggles.
- Write/read same cell same cycle: the display returns the old data. The new data is visible from the next read.

Decomposition:
- Package text_pkg holds:
  - Constants: COLS, ROWS, BUF_DEPTH = 2400, CHAR_W = 8, CHAR_H = 16, SPACE = 7'h20.
  - FSM state enum: IDLE, CLEAR.
  - RGB332 packing helpers.
- Sub-module font_rom_8x16: synchronous 2048x8 ROM, 11-bit address {char[6:0], line[3:0]}, one-cycle latency, initialised from a font file.

Test Plan:
- Reset release → clr_busy = 1 for exactly 2400 clk_50 cycles, wr_ready = 0 throughout, then wr_ready = 1. Every cell then renders the space glyph: RGB = 0 across a full frame.
- Write 'A' (7'h41) at (col 0, row 0), then drive pixel (0..7, 0..15) with video_on = 1 → RGB matches the font_rom 'A' bitmap, FG = 8'hFF, exactly 4 clk_50 after each input.
- Drive hsync_in low for 96 pixels → hsync_out is the same pulse shifted by 4 cycles. Same check for vsync_out.
- Drive column = 640 with video_on = 1 → RGB = 0. Write at col 80, row 0 → handshake completes and cell (0,1) is unchanged.
- cursor_en = 1 at (5, 2) → pixels x 40..47, y 46..47 are FG for 30 frames, BG for the next 30, and repeat.
- clr_req and wr_valid asserted on the same cycle → wr_ready = 0, write not performed, CLEAR entered. A second clr_req at cycle 100 of the sweep → sweep still ends at 2400 cycles.
